// File: rtl/dpro_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dpro_accum                                                 |
// | Description : ALU writeback stage. Passes plain ops through and sums     |
// |               DPRO element products into one saturated dot product.      |
// |               Optional macro DPRO_RELU_EN clamps negative DPRO results.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module dpro_accum #(
    parameter int         DATA_W  = 32,
    parameter int         ACC_W   = 48,
    parameter int         LEN_W   = 8,
    parameter logic [2:0] DPRO_OP = 3'b111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [LEN_W-1:0]  vec_len,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_sat,
    output logic              res_err
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_out   = 2'd2;

    localparam logic signed [ACC_W-1:0] c_max =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_min =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic signed [ACC_W-1:0] r_acc;
    logic [LEN_W-1:0]        r_cnt;
    logic [LEN_W-1:0]        r_len;
    logic [DATA_W-1:0]       r_res_data;
    logic                    r_res_sat;
    logic                    r_res_err;

    logic                    w_accept;
    logic                    w_is_dpro;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_sum;
    logic [LEN_W-1:0]        w_len_in;
    logic [LEN_W-1:0]        w_cnt_inc;
    logic                    w_last_accum;
    logic                    w_hi;
    logic                    w_lo;
    logic [DATA_W-1:0]       w_clip;
    logic [DATA_W-1:0]       w_dpro_res;

    assign in_ready  = ~rst & (r_state != c_st_out);
    assign res_valid = (r_state == c_st_out);
    assign res_data  = r_res_data;
    assign res_sat   = r_res_sat;
    assign res_err   = r_res_err;

    assign w_accept     = in_valid & in_ready;
    assign w_is_dpro    = (op_code == DPRO_OP);
    assign w_prod       = {{(ACC_W-DATA_W){alu_out[DATA_W-1]}}, alu_out};
    // The first beat of a vector starts from zero rather than the stale sum.
    assign w_sum        = ((r_state == c_st_accum) ? r_acc : '0) + w_prod;
    assign w_len_in     = (vec_len == '0) ? LEN_W'(1) : vec_len;
    assign w_cnt_inc    = r_cnt + LEN_W'(1);
    assign w_last_accum = (w_cnt_inc == r_len);

    assign w_hi   = (w_sum > c_max);
    assign w_lo   = (w_sum < c_min);
    assign w_clip = w_hi ? c_max[DATA_W-1:0] :
                    w_lo ? c_min[DATA_W-1:0] : w_sum[DATA_W-1:0];

`ifdef DPRO_RELU_EN
    assign w_dpro_res = w_clip[DATA_W-1] ? '0 : w_clip;
`else
    assign w_dpro_res = w_clip;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    if (!w_is_dpro || (w_len_in == LEN_W'(1))) begin
                        w_state_nxt = c_st_out;
                    end else begin
                        w_state_nxt = c_st_accum;
                    end
                end
            end
            c_st_accum: begin
                if (w_accept && w_is_dpro && w_last_accum) begin
                    w_state_nxt = c_st_out;
                end
            end
            c_st_out: begin
                if (res_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_res_data <= '0;
            r_res_sat  <= 1'b0;
            r_res_err  <= 1'b0;
        end else begin
            // Plain ops arriving mid-vector are swallowed and flagged.
            r_res_err <= w_accept & ~w_is_dpro & (r_state == c_st_accum);
            if (w_accept && (r_state == c_st_idle)) begin
                if (w_is_dpro) begin
                    r_acc <= w_sum;
                    r_cnt <= LEN_W'(1);
                    r_len <= w_len_in;
                    if (w_len_in == LEN_W'(1)) begin
                        r_res_data <= w_dpro_res;
                        r_res_sat  <= w_hi | w_lo;
                    end
                end else begin
                    r_res_data <= alu_out;
                    r_res_sat  <= 1'b0;
                end
            end else if (w_accept && w_is_dpro && (r_state == c_st_accum)) begin
                r_acc <= w_sum;
                r_cnt <= w_cnt_inc;
                if (w_last_accum) begin
                    r_res_data <= w_dpro_res;
                    r_res_sat  <= w_hi | w_lo;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dpro_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dpro_accum                                              |
// | Description : Self-checking bench for dpro_accum: directed vector table, |
// |               hand-written corner sequences and a randomized run.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_dpro_accum;

`ifdef DPRO_RELU_EN
    localparam bit c_relu = 1'b1;
`else
    localparam bit c_relu = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op_code;
    logic [31:0] alu_out;
    logic [7:0]  vec_len;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_sat;
    logic        res_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  len;
        int          n;
        logic [31:0] p0, p1, p2, p3;
        logic [31:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t tbl[$];

    dpro_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_code   (op_code),
        .alu_out   (alu_out),
        .vec_len   (vec_len),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_sat   (res_sat),
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact sum, clipped to signed 32-bit range, optional ReLU.
    function automatic logic [32:0] ref_result(input longint sum, input bit dpro);
        longint v   = sum;
        bit     sat = 1'b0;
        if (v > 64'sd2147483647) begin
            v = 64'sd2147483647;
            sat = 1'b1;
        end else if (v < -64'sd2147483648) begin
            v = -64'sd2147483648;
            sat = 1'b1;
        end
        if (c_relu && dpro && v < 0) v = 0;
        return {sat, v[31:0]};
    endfunction

    task automatic send(input logic [2:0] op, input logic [31:0] val, input logic [7:0] len);
        int t = 0;
        in_valid = 1'b1;
        op_code  = op;
        alu_out  = val;
        vec_len  = len;
        while (!in_ready) begin
            if (t >= 20) begin
                check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
                break;
            end
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        op_code  = 3'd0;
        alu_out  = 32'($urandom);
    endtask

    task automatic expect_result(input string name, input logic [31:0] exp_d,
                                 input logic exp_s, input int hold);
        int t = 0;
        while (!res_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({name, "_valid"}, {63'd0, res_valid}, 64'd1);
        check({name, "_data"}, {32'd0, res_data}, {32'd0, exp_d});
        check({name, "_sat"}, {63'd0, res_sat}, {63'd0, exp_s});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_data"}, {32'd0, res_data}, {32'd0, exp_d});
            check({name, "_hold_ready"}, {63'd0, in_ready}, 64'd0);
            check({name, "_hold_valid"}, {63'd0, res_valid}, 64'd1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({name, "_consumed"}, {63'd0, res_valid}, 64'd0);
        check({name, "_idle_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic add_vec(input logic [2:0] op, input logic [7:0] len, input int n,
                           input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] p2, input logic [31:0] p3,
                           input logic [31:0] ed, input logic es);
        vec_t v;
        v.op = op; v.len = len; v.n = n;
        v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3;
        v.exp_data = ed; v.exp_sat = es;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] pv[4];
        logic [32:0] r;
        longint      sum;
        int          n;
        logic [7:0]  len;
        logic [31:0] v;

        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
        op_code = 3'd0; alu_out = 32'd0; vec_len = 8'd0;

        add_vec(3'b000, 8'd1, 1, 32'd7, 0, 0, 0, 32'd7, 1'b0);
        add_vec(3'b111, 8'd4, 4, 32'd3, -32'sd5, 32'd10, 32'd2, 32'd10, 1'b0);
        add_vec(3'b111, 8'd3, 3, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0,
                32'h7FFFFFFF, 1'b1);
        add_vec(3'b111, 8'd2, 2, 32'h80000000, 32'h80000000, 0, 0,
                c_relu ? 32'd0 : 32'h80000000, 1'b1);
        add_vec(3'b111, 8'd0, 1, -32'sd9, 0, 0, 0, c_relu ? 32'd0 : -32'sd9, 1'b0);
        add_vec(3'b111, 8'd1, 1, 32'd5, 0, 0, 0, 32'd5, 1'b0);
        add_vec(3'b101, 8'd4, 1, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 1'b0);
        add_vec(3'b010, 8'd0, 1, -32'sd1, 0, 0, 0, 32'hFFFFFFFF, 1'b0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_res_data", {32'd0, res_data}, 64'd0);
        check("rst_res_sat", {63'd0, res_sat}, 64'd0);
        check("rst_res_err", {63'd0, res_err}, 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);

        // Directed table
        foreach (tbl[i]) begin
            pv[0] = tbl[i].p0; pv[1] = tbl[i].p1; pv[2] = tbl[i].p2; pv[3] = tbl[i].p3;
            for (int k = 0; k < tbl[i].n; k++) begin
                send(tbl[i].op, pv[k], (k == 0) ? tbl[i].len : 8'($urandom));
                check($sformatf("tbl%0d_valid_beat%0d", i, k), {63'd0, res_valid},
                      {63'd0, (k == tbl[i].n - 1)});
                check($sformatf("tbl%0d_err_beat%0d", i, k), {63'd0, res_err}, 64'd0);
            end
            expect_result($sformatf("tbl%0d", i), tbl[i].exp_data, tbl[i].exp_sat, 0);
        end

        // Backpressure: result held 5 cycles with in_ready low
        send(3'b000, 32'h0000_1234, 8'd0);
        expect_result("backpressure", 32'h0000_1234, 1'b0, 5);

        // Reset in the middle of a 4-element vector, then a clean vector
        send(3'b111, 32'd100, 8'd4);
        send(3'b111, 32'd200, 8'd4);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_result", {63'd0, res_valid}, 64'd0);
        end
        send(3'b111, 32'd1, 8'd2);
        send(3'b111, 32'd1, 8'd9);
        expect_result("post_rst_vec", 32'd2, 1'b0, 0);

        // Plain op inside a vector is dropped with a one-cycle error pulse
        send(3'b111, 32'd4, 8'd3);
        send(3'b000, 32'd99, 8'd3);
        check("drop_err_pulse", {63'd0, res_err}, 64'd1);
        check("drop_no_valid", {63'd0, res_valid}, 64'd0);
        @(negedge clk);
        check("drop_err_clear", {63'd0, res_err}, 64'd0);
        send(3'b111, 32'd4, 8'd1);
        send(3'b111, 32'd4, 8'd1);
        expect_result("drop_vec", 32'd12, 1'b0, 0);

        // Negative dot product (clamped under ReLU)
        send(3'b111, -32'sd6, 8'd2);
        send(3'b111, 32'd2, 8'd2);
        expect_result("neg_vec", c_relu ? 32'd0 : -32'sd4, 1'b0, 0);

        // Randomized vectors against the reference model
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                v = 32'($urandom);
                send(3'($urandom_range(0, 6)), v, 8'($urandom));
                expect_result("rand_pass", v, 1'b0, $urandom_range(0, 2));
            end else begin
                len = 8'($urandom_range(0, 6));
                n   = (len == 0) ? 1 : int'(len);
                sum = 0;
                for (int k = 0; k < n; k++) begin
                    if ($urandom_range(0, 1) == 0)
                        v = $urandom_range(0, 1) ? 32'h7FFFFFF0 + 32'($urandom_range(0, 15))
                                                 : 32'h80000000 + 32'($urandom_range(0, 15));
                    else
                        v = 32'($signed(16'($urandom)));
                    if (k > 0 && $urandom_range(0, 4) == 0) begin
                        send(3'($urandom_range(0, 6)), 32'($urandom), 8'($urandom));
                        check("rand_drop_err", {63'd0, res_err}, 64'd1);
                    end
                    send(3'b111, v, (k == 0) ? len : 8'($urandom));
                    sum += longint'($signed(v));
                    check("rand_latency", {63'd0, res_valid}, {63'd0, (k == n - 1)});
                end
                r = ref_result(sum, 1'b1);
                expect_result("rand_dpro", r[31:0], r[32], $urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
